// File: rtl/opb_register_ppc2simulink_pkg.sv
// Shared types and helpers for the PPC-to-Simulink OPB register:
// transfer states, register word offsets and OPB<->user bit reordering.
package opb_register_ppc2simulink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_WCOUNT = 1'b1;

  // OPB numbers bit 0 as the MSB; user logic numbers bit 31 as the MSB.
  function automatic logic [31:0] opb_to_user(input logic [0:31] opb);
    logic [31:0] u;
    for (int i = 0; i < 32; i++) u[31-i] = opb[i];
    return u;
  endfunction

  function automatic logic [0:31] user_to_opb(input logic [31:0] u);
    logic [0:31] opb;
    for (int i = 0; i < 32; i++) opb[i] = u[31-i];
    return opb;
  endfunction

endpackage

// File: rtl/opb_register_ppc2simulink.sv
// OPB slave holding a 32-bit value written by the PowerPC and presented to
// fabric logic with a one-cycle update strobe, plus a read-only write counter.
module opb_register_ppc2simulink
  import opb_register_ppc2simulink_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h00000000,
  parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5",
  parameter logic [31:0] C_INIT_VALUE = 32'h00000000
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic [31:0] user_data_out,
  output logic        user_data_strobe
);

  state_t      state;
  state_t      next_state;
  logic        word_q;
  logic        rnw_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] data_reg;
  logic [15:0] wcount;
  logic        hit;
  logic        start;
  logic        commit;
  logic [0:31] rd_opb;
  logic        unused_inputs;

  assign unused_inputs = OPB_seqAddr;

  assign hit    = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign start  = (state == IDLE) && hit;
  assign commit = (state == ACK) && !rnw_q && (word_q == REG_DATA) && (be_q != 4'b0000);

  // Read data is captured as the transfer starts, so it reflects pre-write state.
  assign rd_opb = user_to_opb((OPB_ABus[29] == REG_WCOUNT) ? {16'h0000, wcount} : data_reg);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (hit) next_state = ACK;
      ACK:     next_state = GAP;
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state            <= IDLE;
      Sl_xferAck       <= 1'b0;
      Sl_DBus          <= '0;
      data_reg         <= C_INIT_VALUE;
      user_data_strobe <= 1'b0;
      wcount           <= 16'h0000;
      word_q           <= 1'b0;
      rnw_q            <= 1'b0;
      be_q             <= 4'b0000;
      wdata_q          <= 32'h0;
    end else begin
      state            <= next_state;
      Sl_xferAck       <= start;
      Sl_DBus          <= (start && OPB_RNW) ? rd_opb : '0;
      user_data_strobe <= commit;
      if (start) begin
        word_q  <= OPB_ABus[29];
        rnw_q   <= OPB_RNW;
        be_q    <= {OPB_BE[0], OPB_BE[1], OPB_BE[2], OPB_BE[3]};
        wdata_q <= opb_to_user(OPB_DBus);
      end
      // be_q[3] corresponds to OPB_BE[0], i.e. the user MSB byte.
      if (commit) begin
        for (int b = 0; b < 4; b++) begin
          if (be_q[b]) data_reg[8*b +: 8] <= wdata_q[8*b +: 8];
        end
        wcount <= wcount + 16'h0001;
      end
    end
  end

  assign user_data_out = data_reg;
  assign Sl_errAck     = 1'b0;
  assign Sl_retry      = 1'b0;
  assign Sl_toutSup    = 1'b0;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Scoreboard bench for opb_register_ppc2simulink: a behavioural register model
// queues expected read data and strobe values that a monitor checks.
module tb_opb_register_ppc2simulink;

  localparam logic [31:0] BASE = 32'h80001000;
  localparam logic [31:0] HIGH = 32'h800010FF;
  localparam logic [31:0] INIT = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:31] abus = '0;
  logic [0:3]  be_bus = '0;
  logic [0:31] dbus = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seq = 1'b0;
  logic [0:31] sl_dbus;
  logic        sl_ack, sl_err, sl_retry, sl_tout;
  logic [31:0] user_out;
  logic        user_strobe;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [31:0] model_data;
  logic [15:0] model_count;
  logic [31:0] ack_q[$];
  logic [31:0] strobe_q[$];

  opb_register_ppc2simulink #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_INIT_VALUE(INIT)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be_bus),
    .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(sl_dbus), .Sl_xferAck(sl_ack), .Sl_errAck(sl_err),
    .Sl_retry(sl_retry), .Sl_toutSup(sl_tout),
    .user_data_out(user_out), .user_data_strobe(user_strobe)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  // Monitor: pops expectations whenever the DUT acks or strobes.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sl_ack) begin
        if (ack_q.size() == 0) checkOutput("unexpected_ack", 32'd1, 32'd0);
        else checkOutput("read_data", sl_dbus, ack_q.pop_front());
      end else begin
        checkOutput("dbus_idle_zero", sl_dbus, 32'h0);
      end
      if (user_strobe) begin
        if (strobe_q.size() == 0) checkOutput("unexpected_strobe", 32'd1, 32'd0);
        else checkOutput("strobe_data", user_out, strobe_q.pop_front());
      end
      checkOutput("tied_zero", {29'd0, sl_err, sl_retry, sl_tout}, 32'h0);
    end
  end

  function automatic bit is_hit(input logic [31:0] addr);
    return (addr >= BASE) && (addr <= HIGH);
  endfunction

  // Updates the model, queues expectations, then runs one 3-cycle transfer.
  task automatic applyStimulus(input logic [31:0] addr, input logic r, input logic [3:0] be,
                               input logic [31:0] data);
    bit hit;
    bit commit;
    hit    = is_hit(addr);
    commit = hit && !r && !addr[2] && (be != 4'b0000);
    if (hit) ack_q.push_back(r ? (addr[2] ? {16'h0000, model_count} : model_data) : 32'h0);
    if (commit) begin
      for (int k = 0; k < 4; k++) if (be[k]) model_data[8*k +: 8] = data[8*k +: 8];
      model_count = model_count + 16'd1;
      strobe_q.push_back(model_data);
    end
    @(negedge clk);
    abus = addr; rnw = r; be_bus = be; dbus = data; sel = 1'b1;
    @(negedge clk);
    sel = 1'b0; abus = '0; be_bus = '0; dbus = '0; rnw = 1'b0;
    checkOutput("ack_latency", {31'd0, sl_ack}, {31'd0, hit});
    @(negedge clk);
    checkOutput("strobe_pulse", {31'd0, user_strobe}, {31'd0, commit});
  endtask

  initial begin
    int acks;
    logic [31:0] addr;
    model_data  = INIT;
    model_count = 16'h0000;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_user_data", user_out, INIT);
    checkOutput("reset_ack", {31'd0, sl_ack}, 32'd0);
    checkOutput("reset_dbus", sl_dbus, 32'h0);
    checkOutput("reset_strobe", {31'd0, user_strobe}, 32'd0);
    mon_en = 1'b1;

    applyStimulus(BASE + 4, 1'b1, 4'b0000, 32'h0);
    applyStimulus(BASE, 1'b0, 4'b1111, 32'h12345678);
    applyStimulus(BASE + 4, 1'b1, 4'b0000, 32'h0);
    applyStimulus(BASE, 1'b0, 4'b0100, 32'h00AB0000);
    applyStimulus(BASE, 1'b1, 4'b0000, 32'h0);
    applyStimulus(BASE, 1'b0, 4'b0000, 32'hFFFFFFFF);
    applyStimulus(BASE + 4, 1'b1, 4'b0000, 32'h0);
    applyStimulus(BASE + 4, 1'b0, 4'b1111, 32'hCAFEF00D);
    applyStimulus(BASE + 8, 1'b1, 4'b0000, 32'h0);
    checkOutput("partial_write", user_out, 32'h12AB5678);

    // Select held for 9 cycles: one ack per 3 cycles.
    for (int i = 0; i < 3; i++) ack_q.push_back({16'h0000, model_count});
    @(negedge clk);
    abus = BASE + 4; rnw = 1'b1; sel = 1'b1;
    acks = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (sl_ack) acks++;
    end
    sel = 1'b0; abus = '0; rnw = 1'b0;
    checkOutput("held_select_acks", acks, 32'd3);
    repeat (2) @(negedge clk);

    applyStimulus(HIGH + 4, 1'b1, 4'b0000, 32'h0);
    applyStimulus(BASE - 4, 1'b0, 4'b1111, 32'h55555555);

    // Counter wrap: preload to 16'hFFFF rather than issuing 65535 writes.
    @(negedge clk);
    force dut.wcount = 16'hFFFF;
    @(negedge clk);
    release dut.wcount;
    model_count = 16'hFFFF;
    applyStimulus(BASE + 4, 1'b1, 4'b0000, 32'h0);
    applyStimulus(BASE, 1'b0, 4'b0001, 32'h000000EE);
    applyStimulus(BASE + 4, 1'b1, 4'b0000, 32'h0);

    // Reset asserted during the ack cycle of a write: nothing commits.
    ack_q.push_back(32'h0);
    @(negedge clk);
    abus = BASE; rnw = 1'b0; be_bus = 4'b1111; dbus = 32'hFFFFFFFF; sel = 1'b1;
    @(negedge clk);
    sel = 1'b0; abus = '0; be_bus = '0; dbus = '0;
    checkOutput("reset_mid_ack", {31'd0, sl_ack}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_mid_strobe", {31'd0, user_strobe}, 32'd0);
    checkOutput("reset_mid_data", user_out, INIT);
    model_data  = INIT;
    model_count = 16'h0000;
    applyStimulus(BASE + 4, 1'b1, 4'b0000, 32'h0);
    applyStimulus(BASE, 1'b1, 4'b0000, 32'h0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0)
        addr = ($urandom_range(0, 1) == 0) ? BASE - 32'($urandom_range(1, 64))
                                           : HIGH + 32'($urandom_range(1, 64));
      else
        addr = BASE + 32'($urandom_range(0, 255));
      applyStimulus(addr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    end
    applyStimulus(BASE, 1'b1, 4'b0000, 32'h0);
    applyStimulus(BASE + 4, 1'b1, 4'b0000, 32'h0);

    repeat (2) @(negedge clk);
    checkOutput("ack_queue_empty", ack_q.size(), 32'd0);
    checkOutput("strobe_queue_empty", strobe_q.size(), 32'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
